// File: rtl/sbox_layer_sequencer.sv
// Serializes one shared 6-bit S-box across every 6-bit chunk of a wide state word.
// Chunks are issued one per cycle, and results are tagged through a SBOX_LAT-deep delay line.
module sbox_layer_sequencer #(
  parameter int unsigned NUM_CHUNKS = 8,
  parameter int unsigned SBOX_LAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6*NUM_CHUNKS-1:0] in_state,
  output logic [5:0]              sbox_a,
  input  logic [5:0]              sbox_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [6*NUM_CHUNKS-1:0] out_state,
  output logic                    busy
);

  localparam int unsigned W  = 6 * NUM_CHUNKS;
  localparam int unsigned CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    in_reg;
  logic [W-1:0]    out_reg;
  logic [CW-1:0]   issue_cnt;
  logic [5:0]      chunk_sel;
  logic            issue_en;
  logic            cap_vld;
  logic [CW-1:0]   cap_idx;

  assign issue_en = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = ISSUE;
      ISSUE:   if (issue_cnt == LAST) state_nxt = (SBOX_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (cap_vld && cap_idx == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    sbox_a    = issue_en ? chunk_sel : '0;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_state = out_reg;
  end

  always_comb begin
    chunk_sel = '0;
    for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
      if (issue_cnt == CW'(i)) chunk_sel = in_reg[6*i +: 6];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_reg    <= '0;
      out_reg   <= '0;
      issue_cnt <= '0;
    end else begin
      if (in_valid && in_ready) in_reg <= in_state;
      if (issue_en && issue_cnt != LAST) issue_cnt <= issue_cnt + CW'(1);
      else                               issue_cnt <= '0;
      for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
        if (cap_vld && cap_idx == CW'(i)) out_reg[6*i +: 6] <= sbox_b;
      end
    end
  end

  // Each issue is tagged with its chunk index, so a capture lands SBOX_LAT cycles later.
  // The reset clears these tags, which drops every in-flight result.
  if (SBOX_LAT == 0) begin : g_nodl
    always_comb begin
      cap_vld = issue_en;
      cap_idx = issue_cnt;
    end
  end else begin : g_dl
    logic          dl_vld [SBOX_LAT];
    logic [CW-1:0] dl_idx [SBOX_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k < SBOX_LAT; k++) begin
          dl_vld[k] <= 1'b0;
          dl_idx[k] <= '0;
        end
      end else begin
        dl_vld[0] <= issue_en;
        dl_idx[0] <= issue_cnt;
        for (int unsigned k = 1; k < SBOX_LAT; k++) begin
          dl_vld[k] <= dl_vld[k-1];
          dl_idx[k] <= dl_idx[k-1];
        end
      end
    end

    always_comb begin
      cap_vld = dl_vld[SBOX_LAT-1];
      cap_idx = dl_idx[SBOX_LAT-1];
    end
  end

endmodule

// File: tb/tb_sbox_layer_sequencer.sv
// Scoreboard bench for sbox_layer_sequencer: a combinational-S-box instance and a 2-stage-S-box instance
// share the same stimulus and are checked against a per-chunk reference model.
module tb_sbox_layer_sequencer;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] in_state;

  logic        in_ready0, out_valid0, busy0;
  logic [5:0]  sbox_a0, sbox_b0;
  logic [47:0] out_state0;
  logic        in_ready2, out_valid2, busy2;
  logic [5:0]  sbox_a2, sbox_b2, p1, p2;
  logic [47:0] out_state2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench S-box: agrees with SMSL_26_ANF on 0x00, 0x01 and 0x02, and is arbitrary elsewhere
  function automatic logic [5:0] sbox_f(input logic [5:0] x);
    case (x)
      6'h00:   sbox_f = 6'h00;
      6'h01:   sbox_f = 6'h30;
      6'h02:   sbox_f = 6'h3D;
      default: sbox_f = (x * 6'd7 + 6'd13) ^ {x[2:0], x[5:3]};
    endcase
  endfunction

  function automatic logic [47:0] model(input logic [47:0] s);
    logic [47:0] r;
    for (int i = 0; i < N; i++) r[6*i +: 6] = sbox_f(s[6*i +: 6]);
    return r;
  endfunction

  always_comb sbox_b0 = sbox_f(sbox_a0);
  initial begin p1 = '0; p2 = '0; end
  always @(posedge clk) begin
    p1 <= sbox_f(sbox_a2);
    p2 <= p1;
  end
  always_comb sbox_b2 = p2;

  sbox_layer_sequencer #(.NUM_CHUNKS(N), .SBOX_LAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_state(in_state),
    .sbox_a(sbox_a0), .sbox_b(sbox_b0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_state(out_state0), .busy(busy0));

  sbox_layer_sequencer #(.NUM_CHUNKS(N), .SBOX_LAT(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_state(in_state),
    .sbox_a(sbox_a2), .sbox_b(sbox_b2), .out_valid(out_valid2), .out_ready(out_ready),
    .out_state(out_state2), .busy(busy2));

  task automatic chk(input string name, input int d, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut_lat%0d actual %h required %h at cycle %0d", name, d * 2, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual timeout required event at cycle %0d", name, cyc);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [47:0] expq [2][$];
  int          acc_cyc [2];
  int          last_acc [2];
  bit          b2b = 0;
  logic        pv [2] = '{0, 0};
  logic        pr [2] = '{0, 0};
  logic [47:0] ps [2];
  logic        m_ir [2], m_ov [2], m_bz [2];
  logic [5:0]  m_sa [2];
  logic [47:0] m_os [2];
  logic [47:0] m_exp;

  always @(negedge clk) begin
    m_ir = '{in_ready0, in_ready2};
    m_ov = '{out_valid0, out_valid2};
    m_bz = '{busy0, busy2};
    m_sa = '{sbox_a0, sbox_a2};
    m_os = '{out_state0, out_state2};
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        expq[d].delete();
        chk("in_ready_in_rst", d, 48'(m_ir[d]), 48'd0);
        pv[d] = 1'b0;
        pr[d] = 1'b1;
      end else begin
        chk("in_ready_vs_busy", d, 48'(m_ir[d]), 48'(!m_bz[d]));
        if (!m_bz[d]) chk("sbox_a_idle", d, 48'(m_sa[d]), 48'd0);
        if (pv[d] && !pr[d]) chk("hold_under_backpressure", d, {m_ov[d], m_os[d]}, {1'b1, ps[d]});
        if (m_ov[d] && !pv[d]) chk("latency", d, 48'(cyc - acc_cyc[d]), 48'(N + 2 * d + 1));
        if (m_ov[d] && out_ready) begin
          if (expq[d].size() == 0) begin
            chk("unexpected_out_valid", d, 48'd1, 48'd0);
          end else begin
            m_exp = expq[d].pop_front();
            chk("out_state", d, m_os[d], m_exp);
          end
        end
        if (in_valid && m_ir[d]) begin
          expq[d].push_back(model(in_state));
          if (b2b && last_acc[d] >= 0) chk("throughput_gap", d, 48'(cyc - last_acc[d]), 48'(N + 2 * d + 2));
          last_acc[d] = cyc;
          acc_cyc[d]  = cyc;
        end
        pv[d] = m_ov[d];
        pr[d] = out_ready;
        ps[d] = m_os[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  task automatic send(input logic [47:0] s);
    int t = 0;
    while (!(in_ready0 && in_ready2) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) fail_timeout("send_wait_in_ready");
    in_valid = 1'b1;
    in_state = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = rnd48();
  endtask

  task automatic wait_both_valid();
    int t = 0;
    @(negedge clk);
    while (!(out_valid0 && out_valid2) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_timeout("wait_out_valid");
  endtask

  task automatic run_job(input logic [47:0] s, input logic [47:0] exp, input bit seq_chk);
    out_ready = 1'b0;
    send(s);
    if (seq_chk) begin
      for (int i = 0; i < N + 1; i++) begin
        @(negedge clk);
        chk("sbox_a_sequence", 0, 48'(sbox_a0), (i < N) ? 48'(s[5:0]) : 48'd0);
      end
    end
    wait_both_valid();
    chk("directed_out_state", 0, out_state0, exp);
    chk("directed_out_state", 1, out_state2, exp);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual run still active required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ovs;
    logic [47:0] s;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 0, 48'(in_ready0), 48'd1);
    chk("reset_in_ready", 1, 48'(in_ready2), 48'd1);
    chk("reset_out_valid", 0, 48'(out_valid0), 48'd0);
    chk("reset_out_valid", 1, 48'(out_valid2), 48'd0);
    chk("reset_out_state", 0, out_state0, 48'd0);
    chk("reset_out_state", 1, out_state2, 48'd0);
    chk("reset_busy", 0, 48'(busy0), 48'd0);
    chk("reset_busy", 1, 48'(busy2), 48'd0);
    @(posedge clk); #1;

    // all-0x01 state, with the sbox_a issue sequence on the combinational instance
    run_job(48'h041041041041, 48'hC30C30C30C30, 1'b1);
    run_job(48'h000000000002, 48'h00000000003D, 1'b0);
    run_job(48'h000000000000, 48'h000000000000, 1'b0);

    // hold DONE for 5 cycles while in_valid toggles
    out_ready = 1'b0;
    s = rnd48();
    send(s);
    wait_both_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      in_state = rnd48();
      @(negedge clk);
      chk("bp_in_ready", 0, 48'(in_ready0), 48'd0);
      chk("bp_in_ready", 1, 48'(in_ready2), 48'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_handshake", 0, 48'(in_ready0), 48'd1);
    chk("in_ready_after_handshake", 1, 48'(in_ready2), 48'd1);

    // abort a job with reset in cycle 4 after accept
    out_ready = 1'b1;
    send(rnd48());
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 0, 48'(in_ready0), 48'd1);
    chk("abort_in_ready", 1, 48'(in_ready2), 48'd1);
    chk("abort_busy", 0, 48'(busy0), 48'd0);
    chk("abort_busy", 1, 48'(busy2), 48'd0);
    chk("abort_out_valid", 0, 48'(out_valid0), 48'd0);
    chk("abort_out_valid", 1, 48'(out_valid2), 48'd0);
    ovs = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid0 || out_valid2) ovs++;
    end
    chk("aborted_job_no_output", 0, 48'(ovs), 48'd0);
    @(posedge clk); #1;
    s = rnd48();
    run_job(s, model(s), 1'b0);

    // back-to-back random jobs with both handshakes held high
    out_ready = 1'b1;
    last_acc[0] = -1;
    last_acc[1] = -1;
    b2b = 1'b1;
    in_valid = 1'b1;
    in_state = rnd48();
    repeat (200) begin
      @(posedge clk); #1;
      in_state = rnd48();
    end
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    b2b = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", 0, 48'(expq[0].size()), 48'd0);
    chk("scoreboard_drained", 1, 48'(expq[1].size()), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
